uart_tx_framed: RTL and testbench
=================================

UART_TX_FRAMED -- requirements
Module: uart_tx_framed

Interface
REQ-001 SHALL have parameter FREQ_CLK, default 100000000, clock frequency in Hz.
REQ-002 SHALL have parameter TX_SPEED, default 115200, line rate in baud.
REQ-003 SHALL have parameter DATA_WIDTH, default 8, data bits per frame, legal range 5..9.
REQ-004 SHALL have parameter STOP_BITS, default 1, stop bits per frame, legal 1 or 2.
REQ-005 SHALL have port Clk  input  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port Rst  input  1  reset, synchronous, active-high.
REQ-007 SHALL have port Valid  input  1  frame request from upstream.
REQ-008 SHALL have port Data  input  DATA_WIDTH  frame payload, sampled on accept.
REQ-009 SHALL have port Parity_odd  input  1  parity sense: 1 odd, 0 even; sampled on accept.
REQ-010 SHALL have port Ready  output  1  block can accept a frame this cycle.
REQ-011 SHALL have port Busy  output  1  frame in progress.
REQ-012 SHALL have port EOT  output  1  one-cycle pulse, frame completed.
REQ-013 SHALL have port TXD  output  1  serial line, idle high.

Function
REQ-014 SHALL define bit period DIV = FREQ_CLK / TX_SPEED (integer divide); every line bit SHALL last exactly DIV Clk cycles.
REQ-015 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 SHALL accept a frame when Valid && Ready; Data and Parity_odd latched that cycle; upstream may change them afterwards.
REQ-017 SHALL assert Ready in IDLE and in the final cycle of the last stop bit; deasserted otherwise; Valid while Ready=0 ignored.
REQ-018 SHALL drive TXD low (START) on the cycle after accept; latency accept-to-start-edge 1 cycle.
REQ-019 SHALL send DATA_WIDTH data bits LSB first after START, then PARITY (if compiled in), then STOP_BITS stop bits at 1.
REQ-020 SHALL pulse EOT for one cycle in the final cycle of the last stop bit.
REQ-021 SHALL on accept in that same final cycle start the next frame with no idle gap (START follows last stop bit directly); else return to IDLE.
REQ-022 SHALL drive Busy = (state != IDLE).
REQ-023 SHALL keep TXD high in IDLE and STOP; no glitch on state transitions (TXD registered).
REQ-024 SHALL size period and bit counters to hold DIV-1 and DATA_WIDTH-1 respectively; counters wrap to 0 at terminal count.

Reset
REQ-025 SHALL on Rst=1 force state IDLE, TXD=1, Ready=1, Busy=0, EOT=0, counters and shift register 0 at the next edge.
REQ-026 SHALL on Rst mid-frame abandon the frame without EOT; TXD high the cycle after reset sampled.
REQ-027 SHALL give Rst priority over Valid in the same cycle (no accept).

Configuration
REQ-028 SHALL compile the parity bit only when macro UART_TX_PARITY_EN is defined: parity bit = XOR of data bits, inverted when latched Parity_odd=1, one DIV period between last data bit and first stop bit.
REQ-029 SHALL without UART_TX_PARITY_EN omit the PARITY state entirely (DATA goes directly to STOP) and ignore Parity_odd.

Structure
REQ-030 SHALL take the FSM state enum and a bit-period helper constant function from shared package uart_pkg.
REQ-031 SHALL instantiate one sub-module uart_baud_tick generating a one-cycle bit-end tick every DIV cycles, restarted on frame start.

Verification (FREQ_CLK=1000, TX_SPEED=100, DIV=10)
REQ-032 SHALL verify Data=8'hA5, no parity, STOP_BITS=1: TXD = 0,1,0,1,0,0,1,0,1,1 each 10 cycles; EOT at cycle 100 after start edge.
REQ-033 SHALL verify with UART_TX_PARITY_EN, Data=8'h07: parity bit 1 when Parity_odd=0, 0 when Parity_odd=1; frame 110 cycles.
REQ-034 SHALL verify Valid held high across two frames 8'h01, 8'h80: second START immediately after first stop bit, zero idle cycles, two EOT pulses 100 cycles apart.
REQ-035 SHALL verify Rst asserted at cycle 35 of a frame: TXD=1, Busy=0 next cycle, no EOT; following frame 8'h3C transmits correctly.
REQ-036 SHALL verify DATA_WIDTH=5, STOP_BITS=2, Data=5'h13: 1 start + 5 data + 2 stop = 80 cycles; Data changed after accept does not alter TXD.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the framed UART transmitter:
// the transmit FSM state type and the bit-period / counter-width constant functions.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_e;

  // Clock cycles per line bit (integer divide).
  function automatic int bit_period(input int freq_clk, input int tx_speed);
    return freq_clk / tx_speed;
  endfunction

  // Bits needed to hold a counter value of n-1 (at least one bit).
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_framed_if.sv
// Upstream request / serial-line bundle for uart_tx_framed.
// master = frame producer side, slave = transmitter side.
interface uart_tx_framed_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  Valid;
  logic [DATA_WIDTH-1:0] Data;
  logic                  Parity_odd;
  logic                  Ready;
  logic                  Busy;
  logic                  EOT;
  logic                  TXD;

  modport master (
    output Valid, Data, Parity_odd,
    input  Ready, Busy, EOT, TXD
  );

  modport slave (
    input  Valid, Data, Parity_odd,
    output Ready, Busy, EOT, TXD
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Bit-period timer: one-cycle tick at the end of every DIV-cycle line bit,
// restarted from zero when a new frame is accepted.
module uart_baud_tick import uart_pkg::*; #(
  parameter int DIV = 868
) (
  input  logic Clk,
  input  logic Rst,
  input  logic i_restart,
  input  logic i_en,
  output logic o_tick
);
  localparam int CNT_W = cnt_width(DIV);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  assign w_wrap = (r_cnt == CNT_W'(DIV - 1));
  assign o_tick = i_en && w_wrap;

  // Period counter; held at zero while the transmitter is idle.
  always_ff @(posedge Clk) begin
    if (Rst || i_restart) begin
      r_cnt <= '0;
    end else if (i_en) begin
      if (w_wrap) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end else begin
      r_cnt <= '0;
    end
  end
endmodule

// File: rtl/uart_tx_framed.sv
// Framed UART transmitter: start, DATA_WIDTH data bits LSB first, optional parity,
// STOP_BITS stop bits. Parity bit is compiled in only when UART_TX_PARITY_EN is defined.
module uart_tx_framed import uart_pkg::*; #(
  parameter int FREQ_CLK   = 100000000,
  parameter int TX_SPEED   = 115200,
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1
) (
  input  logic            Clk,
  input  logic            Rst,
  uart_tx_framed_if.slave bus
);
  localparam int DIV       = bit_period(FREQ_CLK, TX_SPEED);
  localparam int BIT_CNT_W = cnt_width(DATA_WIDTH);

  tx_state_e             r_state,   w_state_nxt;
  logic [BIT_CNT_W-1:0]  r_bit_cnt, w_bit_cnt_nxt;
  logic                  r_stop_cnt, w_stop_cnt_nxt;
  logic [DATA_WIDTH-1:0] r_shift,   w_shift_nxt;
  logic                  r_txd,     w_txd_nxt;
`ifdef UART_TX_PARITY_EN
  logic                  r_par_bit, w_par_bit_nxt;
`endif

  logic w_tick;
  logic w_last_stop;
  logic w_frame_end;
  logic w_ready;
  logic w_accept;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .Clk       (Clk),
    .Rst       (Rst),
    .i_restart (w_accept),
    .i_en      (r_state != ST_IDLE),
    .o_tick    (w_tick)
  );

  assign w_last_stop = (r_stop_cnt == 1'(STOP_BITS - 1));
  assign w_frame_end = (r_state == ST_STOP) && w_last_stop && w_tick;
  assign w_ready     = (r_state == ST_IDLE) || w_frame_end;
  assign w_accept    = bus.Valid && w_ready;

  assign bus.Ready = w_ready;
  assign bus.EOT   = w_frame_end;
  assign bus.Busy  = (r_state != ST_IDLE);
  assign bus.TXD   = r_txd;

  // Next-state and next line level; the accept path is shared by IDLE and back-to-back frames.
  always_comb begin
    w_state_nxt    = r_state;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_stop_cnt_nxt = r_stop_cnt;
    w_shift_nxt    = r_shift;
    w_txd_nxt      = r_txd;
`ifdef UART_TX_PARITY_EN
    w_par_bit_nxt  = r_par_bit;
`endif
    if (w_accept) begin
      w_state_nxt    = ST_START;
      w_shift_nxt    = bus.Data;
      w_bit_cnt_nxt  = '0;
      w_stop_cnt_nxt = 1'b0;
      w_txd_nxt      = 1'b0;
`ifdef UART_TX_PARITY_EN
      w_par_bit_nxt  = (^bus.Data) ^ bus.Parity_odd;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_txd_nxt = 1'b1;
        end
        ST_START: begin
          if (w_tick) begin
            w_state_nxt = ST_DATA;
            w_txd_nxt   = r_shift[0];
          end else begin
            w_state_nxt = ST_START;
          end
        end
        ST_DATA: begin
          if (w_tick && (r_bit_cnt == BIT_CNT_W'(DATA_WIDTH - 1))) begin
            w_bit_cnt_nxt  = '0;
`ifdef UART_TX_PARITY_EN
            w_state_nxt    = ST_PARITY;
            w_txd_nxt      = r_par_bit;
`else
            w_state_nxt    = ST_STOP;
            w_txd_nxt      = 1'b1;
            w_stop_cnt_nxt = 1'b0;
`endif
          end else if (w_tick) begin
            w_bit_cnt_nxt = r_bit_cnt + BIT_CNT_W'(1);
            w_shift_nxt   = {1'b0, r_shift[DATA_WIDTH-1:1]};
            w_txd_nxt     = r_shift[1];
          end else begin
            w_state_nxt = ST_DATA;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (w_tick) begin
            w_state_nxt    = ST_STOP;
            w_txd_nxt      = 1'b1;
            w_stop_cnt_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_PARITY;
          end
        end
`endif
        ST_STOP: begin
          if (w_tick && w_last_stop) begin
            w_state_nxt    = ST_IDLE;
            w_txd_nxt      = 1'b1;
            w_stop_cnt_nxt = 1'b0;
          end else if (w_tick) begin
            w_stop_cnt_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_STOP;
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_txd_nxt   = 1'b1;
        end
      endcase
    end
  end

  // State and datapath registers; reset abandons any frame in flight.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      r_state    <= ST_IDLE;
      r_bit_cnt  <= '0;
      r_stop_cnt <= 1'b0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
`ifdef UART_TX_PARITY_EN
      r_par_bit  <= 1'b0;
`endif
    end else begin
      r_state    <= w_state_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_stop_cnt <= w_stop_cnt_nxt;
      r_shift    <= w_shift_nxt;
      r_txd      <= w_txd_nxt;
`ifdef UART_TX_PARITY_EN
      r_par_bit  <= w_par_bit_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_uart_tx_framed.sv
// Bench for uart_tx_framed: lane 0 = 8 data bits / 1 stop, lane 1 = 5 data bits / 2 stops,
// both at DIV=10. Follows UART_TX_PARITY_EN for the parity-bit expectation.
module tb_uart_tx_framed;
  localparam int FREQ = 1000;
  localparam int BAUD = 100;
  localparam int DIV  = FREQ / BAUD;
`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL0 = DIV * (1 + 8 + PAR + 1);
  localparam int FL1 = DIV * (1 + 5 + PAR + 2);
  localparam int CAP = 300;

  logic       Clk;
  logic       Rst;
  logic [1:0] tb_valid;
  logic [1:0] tb_par;
  logic [7:0] tb_d0;
  logic [4:0] tb_d1;
  logic [1:0] txd_w, rdy_w, busy_w, eot_w;

  int n_vec;
  int n_err;

  // behavioural model: per lane, whether a frame is on the line, cycle index in it, its bit list
  logic        m_busy [2];
  int          m_pos  [2];
  logic [15:0] m_bits [2];
  int          m_len  [2];

  logic cap_on;
  int   cap_idx;
  logic cap_txd  [2][CAP];
  logic cap_eot  [2][CAP];
  logic cap_busy [2][CAP];

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  for (genvar g = 0; g < 2; g++) begin : g_lane
    localparam int LDW = (g == 0) ? 8 : 5;
    localparam int LSB = (g == 0) ? 1 : 2;
    uart_tx_framed_if #(.DATA_WIDTH(LDW)) u_if ();
    assign u_if.Valid      = tb_valid[g];
    assign u_if.Parity_odd = tb_par[g];
    if (g == 0) begin : g_d0
      assign u_if.Data = tb_d0;
    end else begin : g_d1
      assign u_if.Data = tb_d1;
    end
    assign txd_w[g]  = u_if.TXD;
    assign rdy_w[g]  = u_if.Ready;
    assign busy_w[g] = u_if.Busy;
    assign eot_w[g]  = u_if.EOT;
    uart_tx_framed #(
      .FREQ_CLK(FREQ), .TX_SPEED(BAUD), .DATA_WIDTH(LDW), .STOP_BITS(LSB)
    ) u_dut (
      .Clk (Clk),
      .Rst (Rst),
      .bus (u_if)
    );
  end

  // Line bits of one frame, index 0 = start bit; everything past the payload is 1.
  function automatic logic [15:0] frame_bits(input logic [8:0] d, input int dw, input logic po);
    logic [15:0] b;
    logic        p;
    b    = '1;
    b[0] = 1'b0;
    p    = po;
    for (int i = 0; i < dw; i++) begin
      b[1 + i] = d[i];
      p        = p ^ d[i];
    end
    if (PAR == 1) b[1 + dw] = p;
    return b;
  endfunction

  task automatic check(input string nm, input int lane, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s lane%0d: got %0h, want %0h", nm, lane, act, exp);
    end
  endtask

  // One clock: advance the model with the inputs about to be sampled, then compare at negedge.
  task automatic step();
    for (int l = 0; l < 2; l++) begin
      logic       rdy, v;
      logic [8:0] d;
      rdy = !m_busy[l] || (m_pos[l] == m_len[l] - 1);
      v   = tb_valid[l];
      d   = (l == 0) ? {1'b0, tb_d0} : {4'b0, tb_d1};
      if (Rst) begin
        m_busy[l] = 1'b0;
      end else if (v && rdy) begin
        m_busy[l] = 1'b1;
        m_pos[l]  = 0;
        m_bits[l] = frame_bits(d, (l == 0) ? 8 : 5, tb_par[l]);
      end else if (m_busy[l]) begin
        if (m_pos[l] == m_len[l] - 1) m_busy[l] = 1'b0;
        else m_pos[l] = m_pos[l] + 1;
      end
    end
    @(negedge Clk);
    for (int l = 0; l < 2; l++) begin
      logic last;
      last = m_busy[l] && (m_pos[l] == m_len[l] - 1);
      check("txd",   l, txd_w[l],  m_busy[l] ? m_bits[l][m_pos[l] / DIV] : 1'b1);
      check("ready", l, rdy_w[l],  !m_busy[l] || last);
      check("busy",  l, busy_w[l], m_busy[l]);
      check("eot",   l, eot_w[l],  last);
      if (cap_on && cap_idx < CAP) begin
        cap_txd[l][cap_idx]  = txd_w[l];
        cap_eot[l][cap_idx]  = eot_w[l];
        cap_busy[l][cap_idx] = busy_w[l];
      end
    end
    if (cap_on && cap_idx < CAP) cap_idx++;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  function automatic int eot_count(input int lane, input int upto);
    int c;
    c = 0;
    for (int i = 0; i < upto && i < CAP; i++) if (cap_eot[lane][i]) c++;
    return c;
  endfunction

  initial begin
    logic [15:0] pat0, pat1;
    n_vec = 0; n_err = 0;
    m_busy[0] = 1'b0; m_busy[1] = 1'b0;
    m_pos[0] = 0; m_pos[1] = 0;
    m_bits[0] = '1; m_bits[1] = '1;
    m_len[0] = FL0; m_len[1] = FL1;
    cap_on = 1'b0; cap_idx = 0;
    Rst = 1'b1; tb_valid = 2'b00; tb_par = 2'b00; tb_d0 = 8'h00; tb_d1 = 5'h00;
    run(3);
    Rst = 1'b0;
    step();
    check("rst_txd",   0, txd_w[0],  1'b1);
    check("rst_ready", 0, rdy_w[0],  1'b1);
    check("rst_busy",  0, busy_w[0], 1'b0);
    check("rst_eot",   0, eot_w[0],  1'b0);

    // A5 on lane 0, 13 on lane 1; payload changed right after accept
    tb_valid = 2'b11; tb_d0 = 8'hA5; tb_d1 = 5'h13; tb_par = 2'b00;
    cap_on = 1'b1; cap_idx = 0;
    step();
    tb_valid = 2'b00; tb_d0 = 8'h5A; tb_d1 = 5'h0C;
    run(FL0 + 4);
    cap_on = 1'b0;
`ifdef UART_TX_PARITY_EN
    pat0 = 16'h054A; pat1 = 16'h01E6;
`else
    pat0 = 16'h034A; pat1 = 16'h00E6;
`endif
    for (int k = 0; k < FL0 / DIV; k++) check("a5_bit", 0, cap_txd[0][k * DIV + 5], pat0[k]);
    for (int k = 0; k < FL1 / DIV; k++) check("h13_bit", 1, cap_txd[1][k * DIV + 5], pat1[k]);
    check("a5_start_edge", 0, cap_txd[0][0], 1'b0);
    check("a5_eot_pos", 0, cap_eot[0][FL0 - 1], 1'b1);
    check("a5_eot_cnt", 0, eot_count(0, FL0 + 4), 1);
    check("a5_idle_after", 0, cap_busy[0][FL0], 1'b0);
    check("h13_eot_pos", 1, cap_eot[1][FL1 - 1], 1'b1);
    check("h13_len", 1, cap_busy[1][FL1], 1'b0);

    // 07 with both parity senses: bit 9 is the parity bit or the stop bit
    for (int p = 0; p < 2; p++) begin
      tb_valid = 2'b01; tb_d0 = 8'h07; tb_par = 2'(p);
      cap_on = 1'b1; cap_idx = 0;
      step();
      tb_valid = 2'b00; tb_d0 = 8'hFF; tb_par = 2'b00;
      run(FL0 + 2);
      cap_on = 1'b0;
`ifdef UART_TX_PARITY_EN
      check("p07_parity", 0, cap_txd[0][95], (p == 0) ? 1'b1 : 1'b0);
`else
      check("p07_stop", 0, cap_txd[0][95], 1'b1);
`endif
      check("p07_eot_pos", 0, cap_eot[0][FL0 - 1], 1'b1);
    end

    // Valid held high across two frames: no idle gap
    tb_valid = 2'b01; tb_d0 = 8'h01;
    cap_on = 1'b1; cap_idx = 0;
    step();
    tb_d0 = 8'h80;
    run(FL0);
    tb_valid = 2'b00;
    run(FL0 + 2);
    cap_on = 1'b0;
    check("b2b_first_d0", 0, cap_txd[0][15], 1'b1);
    check("b2b_eot1", 0, cap_eot[0][FL0 - 1], 1'b1);
    check("b2b_start2", 0, cap_txd[0][FL0], 1'b0);
    check("b2b_busy_gap", 0, cap_busy[0][FL0], 1'b1);
    check("b2b_second_d0", 0, cap_txd[0][FL0 + 15], 1'b0);
    check("b2b_second_d7", 0, cap_txd[0][FL0 + 85], 1'b1);
    check("b2b_eot2", 0, cap_eot[0][2 * FL0 - 1], 1'b1);
    check("b2b_eot_cnt", 0, eot_count(0, 2 * FL0 + 2), 2);

    // Reset mid-frame, then 3C
    tb_valid = 2'b01; tb_d0 = 8'hFF;
    cap_on = 1'b1; cap_idx = 0;
    step();
    tb_valid = 2'b00;
    run(35);
    Rst = 1'b1;
    step();
    Rst = 1'b0;
    cap_on = 1'b0;
    check("rst_mid_txd",  0, cap_txd[0][36],  1'b1);
    check("rst_mid_busy", 0, cap_busy[0][36], 1'b0);
    check("rst_mid_eot",  0, eot_count(0, 37), 0);
    tb_valid = 2'b01; tb_d0 = 8'h3C; tb_par = 2'b00;
    cap_on = 1'b1; cap_idx = 0;
    step();
    tb_valid = 2'b00;
    run(FL0 + 2);
    cap_on = 1'b0;
`ifdef UART_TX_PARITY_EN
    pat0 = 16'h0478;
`else
    pat0 = 16'h0278;
`endif
    for (int k = 0; k < FL0 / DIV; k++) check("h3c_bit", 0, cap_txd[0][k * DIV + 5], pat0[k]);
    check("h3c_eot_pos", 0, cap_eot[0][FL0 - 1], 1'b1);

    // Random traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      Rst      = ($urandom_range(0, 599) == 0);
      tb_valid = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
      tb_d0    = 8'($urandom());
      tb_d1    = 5'($urandom());
      tb_par   = 2'($urandom());
      step();
    end
    Rst = 1'b0; tb_valid = 2'b00;
    run(FL1 + 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
